keypad_lock_ctrl: RTL and testbench
===================================

# keypad_lock_ctrl

Parametrised keypad combination-lock controller, the successor to the single-bit combination lock. It collects a multi-digit code from a keypad strobe, compares it against an internal code register, and counts failed attempts up to a configurable limit. It adds an alarm-acknowledge plus timed lockout, auto-relock of the open state, and in-block code change. It sits between the keypad decoder and the door actuator and alarm drivers.

## Interface
- DIGITS, default 4: code length in digits (≥1).
- DIGIT_W, default 4: bits per digit.
- MAX_TRIES, default 3: consecutive failures that trigger Alarm (≥1).
- OPEN_CYC, default 50: cycles Open stays asserted before auto-relock (≥1).
- LOCKOUT_CYC, default 1000: lockout duration after alarm acknowledge (≥1).
- DEFAULT_CODE, default 0: code loaded at reset, DIGITS*DIGIT_W bits.
- Clock  in  1  single clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- Digit  in  DIGIT_W  keypad digit value, sampled when DigitValid=1.
- DigitValid  in  1  one-cycle strobe: append Digit to entry buffer.
- Enter  in  1  one-cycle strobe: submit entry.
- Change  in  1  one-cycle strobe: request code change (entry must hold current code).
- Clear  in  1  one-cycle strobe: discard entry buffer.
- AlarmAck  in  1  acknowledge alarm.
- Open  out  1  unlocked.
- New  out  1  awaiting new code.
- Alarm  out  1  attempt limit reached.
- Locked  out  1  lockout timer running.
- Tries  out  $clog2(MAX_TRIES+1)  current consecutive failure count.

## Operation
- Reset: state IDLE, code register = DEFAULT_CODE, entry buffer and digit count = 0, Tries = 0, all outputs 0.
- Entry buffer: DigitValid shifts Digit into the low digit and increments count, saturating at DIGITS. Digits arriving once count = DIGITS are ignored. The buffer and count clear on Clear, on any Enter or Change, and on every state transition.
- An entry is correct when count = DIGITS and buffer = code register.
- Input priority within one cycle: Clear > Enter > Change > DigitValid. Only the highest-priority strobe acts.
- IDLE:
  - Enter, correct -> OPEN, Tries = 0.
  - Change, correct -> NEW, Tries = 0.
  - Enter or Change, incorrect -> Tries+1. If the new Tries = MAX_TRIES -> ALARM, else stay in IDLE.
- OPEN: Enter, or OPEN_CYC cycles elapsed -> IDLE. Other inputs are ignored.
- NEW:
  - Enter with count = DIGITS -> code register = buffer, -> IDLE.
  - Enter with count < DIGITS -> IDLE, code unchanged.
  - Change -> IDLE (abort), code unchanged.
- ALARM: holds until AlarmAck = 1, then -> LOCKOUT. All keypad strobes are ignored.
- LOCKOUT: all inputs ignored. After LOCKOUT_CYC cycles -> IDLE with Tries = 0.
- Outputs are Moore and registered from state: Open = OPEN, New = NEW, Alarm = ALARM, Locked = LOCKOUT.
- A single shared down-counter serves OPEN and LOCKOUT. It is loaded on entry to either state.

## Timing
- A strobe sampled at edge N updates state at edge N. The corresponding output is valid in the cycle after edge N (latency 1).
- For an entry made on the clock edge that enters OPEN, Open stays high for exactly OPEN_CYC cycles unless Enter ends it earlier.
- Locked is high for exactly LOCKOUT_CYC cycles, starting the cycle after the AlarmAck edge.
- Resetn low at any point, including mid-lockout or mid-NEW, immediately forces reset values. The code register reverts to DEFAULT_CODE.
- With MAX_TRIES = 1, the first failure goes directly to ALARM.

## Structure
- Shared package lock_pkg: state enum (IDLE, OPEN, NEW, ALARM, LOCKOUT) and width helper constants.
- One sub-module, digit_entry_buf: shift buffer plus saturating count, with clear and compare-equal output.
- The FSM, code register, try counter and timer stay in keypad_lock_ctrl.

## Test plan
- Reset, default code 0000: enter 0,0,0,0 + Enter -> Open=1 next cycle, Open falls after 50 cycles, Tries=0.
- Enter 1,2,3,4 three times with code 0000 -> Tries 1, 2, then Alarm=1. Keypad strobes ignored while in ALARM. AlarmAck -> Locked=1 for 1000 cycles -> IDLE, Tries=0.
- Change with 0,0,0,0 -> New=1. Enter 9,8,7,6 + Enter -> code 9876. Old code 0000 then fails, 9876 opens.
- In NEW, enter 5,5 + Enter -> IDLE with code unchanged. Also in NEW, Change -> abort with code unchanged.
- Five digits 0,0,0,0,7 + Enter -> opens (fifth digit ignored). Three digits + Enter -> failure, Tries=1.
- Simultaneous Clear+Enter -> buffer cleared, no attempt counted. Resetn low mid-LOCKOUT -> all outputs 0, code = DEFAULT_CODE.

Source files
------------

// File: rtl/lock_pkg.sv
// Shared types and width helpers for the keypad combination lock.
package lock_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    OPEN    = 3'd1,
    NEW     = 3'd2,
    ALARM   = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_e;

  localparam int STATE_W = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/keypad_lock_ctrl_digit_entry_buf.sv
// Keypad entry buffer: shifts digits in at the low end, saturating digit count,
// and flags a full entry that equals the compare value.
module digit_entry_buf #(
  parameter int DIGITS  = 4,
  parameter int DIGIT_W = 4,
  localparam int CODE_W = DIGITS * DIGIT_W,
  localparam int CNT_W  = $clog2(DIGITS + 1)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clr_i,
  input  logic               push_i,
  input  logic [DIGIT_W-1:0] digit_i,
  input  logic [CODE_W-1:0]  cmp_i,
  output logic [CODE_W-1:0]  buf_o,
  output logic               full_o,
  output logic               match_o
);

  logic [CODE_W-1:0] buf_q, buf_d, shifted;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  if (DIGITS == 1) begin : g_one
    assign shifted = digit_i;
  end else begin : g_many
    assign shifted = {buf_q[CODE_W-DIGIT_W-1:0], digit_i};
  end

  assign full_o  = (cnt_q == CNT_W'(DIGITS));
  assign match_o = full_o && (buf_q == cmp_i);
  assign buf_o   = buf_q;

  // Clear wins over a push; digits beyond a full entry are dropped.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      buf_d = '0;
      cnt_d = '0;
    end else if (push_i && !full_o) begin
      buf_d = shifted;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
      cnt_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_lock_ctrl.sv
// Keypad combination-lock controller: code check, failure counting, alarm with
// timed lockout, auto-relocking open state and in-place code change.
module keypad_lock_ctrl
  import lock_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIGIT_W     = 4,
  parameter int MAX_TRIES   = 3,
  parameter int OPEN_CYC    = 50,
  parameter int LOCKOUT_CYC = 1000,
  parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input  logic                             Clock,
  input  logic                             Resetn,
  input  logic [DIGIT_W-1:0]               Digit,
  input  logic                             DigitValid,
  input  logic                             Enter,
  input  logic                             Change,
  input  logic                             Clear,
  input  logic                             AlarmAck,
  output logic                             Open,
  output logic                             New,
  output logic                             Alarm,
  output logic                             Locked,
  output logic [$clog2(MAX_TRIES+1)-1:0]   Tries
);

  localparam int CODE_W  = DIGITS * DIGIT_W;
  localparam int TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int TMR_W   = $clog2(max_int(OPEN_CYC, LOCKOUT_CYC) + 1);

  lock_state_e        state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d, tries_inc;
  logic [CODE_W-1:0]  code_q, code_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;

  logic              act_enter, act_change, act_digit;
  logic              buf_clr, buf_push, buf_full, buf_match;
  logic [CODE_W-1:0] buf_val;

  assign act_enter  = Enter & ~Clear;
  assign act_change = Change & ~Clear & ~Enter;
  assign act_digit  = DigitValid & ~Clear & ~Enter & ~Change;
  assign tries_inc  = tries_q + TRIES_W'(1);

  // Any strobe other than a digit, or any state change, empties the entry.
  assign buf_clr  = Clear | Enter | Change | (state_d != state_q);
  assign buf_push = act_digit & ((state_q == IDLE) | (state_q == NEW));

  digit_entry_buf #(
    .DIGITS  (DIGITS),
    .DIGIT_W (DIGIT_W)
  ) u_entry (
    .clk_i   (Clock),
    .rst_ni  (Resetn),
    .clr_i   (buf_clr),
    .push_i  (buf_push),
    .digit_i (Digit),
    .cmp_i   (code_q),
    .buf_o   (buf_val),
    .full_o  (buf_full),
    .match_o (buf_match)
  );

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    code_d  = code_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      IDLE: begin
        if (act_enter || act_change) begin
          if (buf_match) begin
            tries_d = '0;
            if (act_enter) begin
              state_d = OPEN;
              tmr_d   = TMR_W'(OPEN_CYC - 1);
            end else begin
              state_d = NEW;
            end
          end else begin
            tries_d = tries_inc;
            if (tries_inc == TRIES_W'(MAX_TRIES)) state_d = ALARM;
          end
        end
      end
      OPEN: begin
        if (act_enter || tmr_q == '0) state_d = IDLE;
        else                          tmr_d   = tmr_q - TMR_W'(1);
      end
      NEW: begin
        if (act_enter) begin
          if (buf_full) code_d = buf_val;
          state_d = IDLE;
        end else if (act_change) begin
          state_d = IDLE;
        end
      end
      ALARM: begin
        if (AlarmAck) begin
          state_d = LOCKOUT;
          tmr_d   = TMR_W'(LOCKOUT_CYC - 1);
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          state_d = IDLE;
          tries_d = '0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      tries_q <= '0;
      code_q  <= DEFAULT_CODE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      code_q  <= code_d;
      tmr_q   <= tmr_d;
    end
  end

  assign Open   = (state_q == OPEN);
  assign New    = (state_q == NEW);
  assign Alarm  = (state_q == ALARM);
  assign Locked = (state_q == LOCKOUT);
  assign Tries  = tries_q;

endmodule

// File: tb/tb_keypad_lock_ctrl.sv
// Directed bench for keypad_lock_ctrl with default parameters (4x4-bit code 0000).
module tb_keypad_lock_ctrl;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] Digit;
  logic       DigitValid, Enter, Change, Clear, AlarmAck;
  logic       Open, New, Alarm, Locked;
  logic [1:0] Tries;

  int tests = 0;
  int fails = 0;

  keypad_lock_ctrl dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .Digit      (Digit),
    .DigitValid (DigitValid),
    .Enter      (Enter),
    .Change     (Change),
    .Clear      (Clear),
    .AlarmAck   (AlarmAck),
    .Open       (Open),
    .New        (New),
    .Alarm      (Alarm),
    .Locked     (Locked),
    .Tries      (Tries)
  );

  always #5 Clock = ~Clock;

  // Status word {Open, New, Alarm, Locked, Tries[1:0]}
  wire [5:0] st = {Open, New, Alarm, Locked, Tries};

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    Digit = d; DigitValid = 1'b1;
    tick();
    DigitValid = 1'b0;
  endtask

  task automatic key_code(input logic [15:0] c, input int n);
    for (int i = 0; i < n; i++) press_digit(c[15-4*i -: 4]);
  endtask

  task automatic press_enter();
    Enter = 1'b1; tick(); Enter = 1'b0;
  endtask

  task automatic press_change();
    Change = 1'b1; tick(); Change = 1'b0;
  endtask

  task automatic test_reset();
    Resetn = 1'b0; Digit = '0; DigitValid = 0; Enter = 0; Change = 0; Clear = 0; AlarmAck = 0;
    #2;
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL reset_outputs: got %b expected %b", st, 6'b000000); end
    tick(); tick();
    Resetn = 1'b1;
    tick();
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL post_reset_idle: got %b expected %b", st, 6'b000000); end
  endtask

  task automatic test_open();
    int n;
    key_code(16'h0000, 4);
    press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL open_on_correct: got %b expected %b", st, 6'b100000); end
    n = 1;
    while (Open && n < 200) begin tick(); if (Open) n++; end
    tests++;
    if (n !== 50) begin fails++; $display("FAIL open_duration: got %0d expected %0d", n, 50); end
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL open_relock: got %b expected %b", st, 6'b000000); end
  endtask

  task automatic test_digits();
    key_code(16'h0000, 4);
    press_digit(4'd7);
    press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL fifth_digit_ignored: got %b expected %b", st, 6'b100000); end
    press_enter();
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL enter_closes_open: got %b expected %b", st, 6'b000000); end
    key_code(16'h0000, 3);
    press_enter();
    tests++;
    if (st !== 6'b0000_01) begin fails++; $display("FAIL short_entry_fails: got %b expected %b", st, 6'b000001); end
    key_code(16'h0000, 4);
    press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL correct_clears_tries: got %b expected %b", st, 6'b100000); end
    press_enter();
  endtask

  task automatic test_alarm();
    int n;
    key_code(16'h1234, 4); press_enter();
    tests++;
    if (st !== 6'b0000_01) begin fails++; $display("FAIL tries_1: got %b expected %b", st, 6'b000001); end
    key_code(16'h1234, 4); press_enter();
    tests++;
    if (st !== 6'b0000_10) begin fails++; $display("FAIL tries_2: got %b expected %b", st, 6'b000010); end
    key_code(16'h1234, 4); press_enter();
    tests++;
    if (st !== 6'b0010_11) begin fails++; $display("FAIL alarm_on_third: got %b expected %b", st, 6'b001011); end
    key_code(16'h0000, 4); press_enter(); press_change();
    tests++;
    if (st !== 6'b0010_11) begin fails++; $display("FAIL alarm_ignores_keys: got %b expected %b", st, 6'b001011); end
    AlarmAck = 1'b1; tick(); AlarmAck = 1'b0;
    tests++;
    if (st !== 6'b0001_11) begin fails++; $display("FAIL lockout_entered: got %b expected %b", st, 6'b000111); end
    n = 1;
    while (Locked && n < 1200) begin tick(); if (Locked) n++; end
    tests++;
    if (n !== 1000) begin fails++; $display("FAIL lockout_duration: got %0d expected %0d", n, 1000); end
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL lockout_exit_idle: got %b expected %b", st, 6'b000000); end
  endtask

  task automatic test_change();
    key_code(16'h0000, 4); press_change();
    tests++;
    if (st !== 6'b0100_00) begin fails++; $display("FAIL change_to_new: got %b expected %b", st, 6'b010000); end
    key_code(16'h9876, 4); press_enter();
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL new_commit_idle: got %b expected %b", st, 6'b000000); end
    key_code(16'h0000, 4); press_enter();
    tests++;
    if (st !== 6'b0000_01) begin fails++; $display("FAIL old_code_rejected: got %b expected %b", st, 6'b000001); end
    key_code(16'h9876, 4); press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL new_code_opens: got %b expected %b", st, 6'b100000); end
    press_enter();
  endtask

  task automatic test_new_abort();
    key_code(16'h9876, 4); press_change();
    key_code(16'h5500, 2); press_enter();
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL new_short_to_idle: got %b expected %b", st, 6'b000000); end
    key_code(16'h9876, 4); press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL code_kept_after_short: got %b expected %b", st, 6'b100000); end
    press_enter();
    key_code(16'h9876, 4); press_change();
    key_code(16'h1111, 4); press_change();
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL new_change_abort: got %b expected %b", st, 6'b000000); end
    key_code(16'h1111, 4); press_enter();
    tests++;
    if (st !== 6'b0000_01) begin fails++; $display("FAIL aborted_code_rejected: got %b expected %b", st, 6'b000001); end
    key_code(16'h9876, 4); press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL code_kept_after_abort: got %b expected %b", st, 6'b100000); end
    press_enter();
  endtask

  task automatic test_clear_enter();
    key_code(16'h1234, 4);
    Clear = 1'b1; Enter = 1'b1; tick(); Clear = 1'b0; Enter = 1'b0;
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL clear_beats_enter: got %b expected %b", st, 6'b000000); end
    key_code(16'h9876, 4); press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL buffer_was_cleared: got %b expected %b", st, 6'b100000); end
    press_enter();
  endtask

  task automatic test_reset_lockout();
    for (int i = 0; i < 3; i++) begin key_code(16'h0000, 4); press_enter(); end
    AlarmAck = 1'b1; tick(); AlarmAck = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (st !== 6'b0001_11) begin fails++; $display("FAIL mid_lockout: got %b expected %b", st, 6'b000111); end
    Resetn = 1'b0;
    #1;
    tests++;
    if (st !== 6'b0000_00) begin fails++; $display("FAIL async_reset_lockout: got %b expected %b", st, 6'b000000); end
    #3;
    Resetn = 1'b1;
    tick();
    key_code(16'h0000, 4); press_enter();
    tests++;
    if (st !== 6'b1000_00) begin fails++; $display("FAIL default_code_restored: got %b expected %b", st, 6'b100000); end
    press_enter();
  endtask

  initial begin
    test_reset();
    test_open();
    test_digits();
    test_alarm();
    test_change();
    test_new_abort();
    test_clear_enter();
    test_reset_lockout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
